// File: rtl/audio_psg_voice_seq.sv
// 16-voice PSG sequencer: walks the attribute RAM once per sample tick,
// advances per-voice phase, shapes/scales each waveform and sums a stereo sample.
module audio_psg_voice_seq (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        rd_en_o,
    output logic [3:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        busy_o,
    output logic [15:0] left_o,
    output logic [15:0] right_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        PROC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  v_q, v_d;
    logic [16:0] ph_q [16];
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] acc_l_q, acc_l_d;
    logic [15:0] acc_r_q, acc_r_d;
    logic [15:0] left_q, left_d;
    logic [15:0] right_q, right_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        rd_en_q, rd_en_d;
    logic [3:0]  rd_addr_q, rd_addr_d;

    logic [15:0] freq;
    logic [5:0]  vol;
    logic        l_en;
    logic        r_en;
    logic [5:0]  pw;
    logic [1:0]  wave;

    assign freq = rd_data_i[15:0];
    assign vol  = rd_data_i[21:16];
    assign l_en = rd_data_i[22];
    assign r_en = rd_data_i[23];
    assign pw   = rd_data_i[29:24];
    assign wave = rd_data_i[31:30];

    logic [16:0]        ph_new;
    logic [5:0]         p;
    logic [5:0]         u;
    logic signed [5:0]  s;
    logic signed [11:0] prod;
    logic [15:0]        prod_ext;
    logic               lfsr_fb;
    logic               ph_we;

    // Per-voice waveform datapath, only meaningful while in PROC
    always_comb begin
        ph_new = ph_q[v_q] + {1'b0, freq};
        p      = ph_new[16:11];
        u      = 6'd0;
        case (wave)
            2'd0:    u = (p < pw) ? 6'd63 : 6'd0;
            2'd1:    u = p;
            2'd2:    u = ph_new[16] ? ~ph_new[15:10] : ph_new[15:10];
            default: u = lfsr_q[5:0];
        endcase
        s        = $signed(u - 6'd32);
        prod     = s * $signed({1'b0, vol});
        prod_ext = {{4{prod[11]}}, prod};
        lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        lfsr_d    = lfsr_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        ph_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    v_d       = 4'd0;
                    acc_l_d   = 16'd0;
                    acc_r_d   = 16'd0;
                    state_d   = ADDR;
                    rd_en_d   = 1'b1;
                    rd_addr_d = 4'd0;
                    busy_d    = 1'b1;
                end
            end
            ADDR: begin
                state_d = PROC;
                rd_en_d = 1'b0;
            end
            PROC: begin
                ph_we   = 1'b1;
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                acc_l_d = l_en ? (acc_l_q + prod_ext) : acc_l_q;
                acc_r_d = r_en ? (acc_r_q + prod_ext) : acc_r_q;
                if (v_q == 4'd15) begin
                    // Final voice: publish the sums including this voice
                    left_d  = acc_l_d;
                    right_d = acc_r_d;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    v_d       = v_q + 4'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = v_q + 4'd1;
                    state_d   = ADDR;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            v_q       <= 4'd0;
            lfsr_q    <= 16'h0001;
            acc_l_q   <= 16'd0;
            acc_r_q   <= 16'd0;
            left_q    <= 16'd0;
            right_q   <= 16'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                ph_q[i] <= 17'd0;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            lfsr_q    <= lfsr_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            if (ph_we) begin
                ph_q[v_q] <= ph_new;
            end
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign busy_o    = busy_q;
    assign left_o    = left_q;
    assign right_o   = right_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_audio_psg_voice_seq.sv
// Directed bench for audio_psg_voice_seq with a registered-read attribute RAM model.
module tb_audio_psg_voice_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        rd_en_o;
    logic [3:0]  rd_addr_o;
    logic [31:0] rd_data_i = 32'd0;
    logic        busy_o;
    logic [15:0] left_o;
    logic [15:0] right_o;
    logic        valid_o;

    logic [31:0] mem [16];
    int errors = 0;
    int checks = 0;

    audio_psg_voice_seq dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .busy_o    (busy_o),
        .left_o    (left_o),
        .right_o   (right_o),
        .valid_o   (valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    end

    function automatic logic [31:0] attr(input logic [1:0] wave, input logic [5:0] pw,
                                         input logic r, input logic l,
                                         input logic [5:0] vol, input logic [15:0] freq);
        return {wave, pw, r, l, vol, freq};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // One sweep from a start pulse; optional extra starts at T+s1/T+s2 and reset at T+rst_at
    task automatic sweep(input int s1, input int s2, input int rst_at,
                         output int vcyc, output int vcnt, output int rdcnt,
                         output bit addr_ok, output int busycnt);
        vcyc = 0; vcnt = 0; rdcnt = 0; addr_ok = 1'b1; busycnt = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (valid_o) begin
                if (vcnt == 0) vcyc = k;
                vcnt++;
            end
            if (rd_en_o) begin
                if (rd_addr_o !== rdcnt[3:0]) addr_ok = 1'b0;
                rdcnt++;
            end
            if (busy_o) busycnt++;
            start_i = (k == s1 || k == s2) ? 1'b1 : 1'b0;
            if (rst_at != 0 && k == rst_at) rst_n_i = 1'b0;
            if (rst_at != 0 && k == rst_at + 2) rst_n_i = 1'b1;
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        int vc, vn, rc, bc;
        bit ok;
        do_reset();
        #1;
        checks++; if (left_o !== 16'd0 || right_o !== 16'd0) begin errors++;
            $display("FAIL reset_lr: got %h/%h want 0/0", left_o, right_o); end
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_vb: got valid=%b busy=%b want 0/0", valid_o, busy_o); end
        checks++; if (rd_en_o !== 1'b0 || rd_addr_o !== 4'd0) begin errors++;
            $display("FAIL reset_rd: got en=%b addr=%0d want 0/0", rd_en_o, rd_addr_o); end
        clear_mem();
        mem[0] = attr(2'd1, 6'd0, 1'b0, 1'b1, 6'd63, 16'h0800);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        checks++; if (left_o !== 16'd0 || right_o !== 16'd0) begin errors++;
            $display("FAIL async_reset_lr: got %h/%h want 0/0", left_o, right_o); end
        checks++; if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || rd_addr_o !== 4'd0) begin errors++;
            $display("FAIL async_reset_ctl: got busy=%b en=%b addr=%0d want 0/0/0", busy_o, rd_en_o, rd_addr_o); end
        @(negedge clk_i);
        start_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0 || rd_en_o !== 1'b0) begin errors++;
            $display("FAIL start_in_reset: got busy=%b en=%b want 0/0", busy_o, rd_en_o); end
        start_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sawtooth();
        int vc, vn, rc, bc;
        bit ok;
        do_reset();
        clear_mem();
        mem[0] = attr(2'd1, 6'd0, 1'b0, 1'b1, 6'd63, 16'h0800);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if (vc != 33 || vn != 1) begin errors++;
            $display("FAIL saw1_valid: got cycle=%0d count=%0d want 33/1", vc, vn); end
        checks++; if ($signed(left_o) !== -1953 || right_o !== 16'd0) begin errors++;
            $display("FAIL saw1_out: got %0d/%0d want -1953/0", $signed(left_o), $signed(right_o)); end
        $display("saw sweep1 left=%0d right=%0d valid_cycle=%0d", $signed(left_o), $signed(right_o), vc);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if (vc != 33 || vn != 1) begin errors++;
            $display("FAIL saw2_valid: got cycle=%0d count=%0d want 33/1", vc, vn); end
        checks++; if ($signed(left_o) !== -1890) begin errors++;
            $display("FAIL saw2_out: got %0d want -1890", $signed(left_o)); end
        $display("saw sweep2 left=%0d valid_cycle=%0d", $signed(left_o), vc);
        repeat (5) @(posedge clk_i);
        #1;
        checks++; if ($signed(left_o) !== -1890 || valid_o !== 1'b0) begin errors++;
            $display("FAIL saw_hold: got %0d valid=%b want -1890/0", $signed(left_o), valid_o); end
    endtask

    task automatic test_pulse();
        int vc, vn, rc, bc;
        bit ok;
        do_reset();
        clear_mem();
        mem[3] = attr(2'd0, 6'd32, 1'b1, 1'b1, 6'd63, 16'h0000);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if ($signed(left_o) !== 1953 || $signed(right_o) !== 1953) begin errors++;
            $display("FAIL pulse_pw32: got %0d/%0d want 1953/1953", $signed(left_o), $signed(right_o)); end
        $display("pulse pw32 left=%0d right=%0d", $signed(left_o), $signed(right_o));
        mem[3] = attr(2'd0, 6'd0, 1'b1, 1'b1, 6'd63, 16'h0000);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if ($signed(left_o) !== -2016 || $signed(right_o) !== -2016) begin errors++;
            $display("FAIL pulse_pw0: got %0d/%0d want -2016/-2016", $signed(left_o), $signed(right_o)); end
        $display("pulse pw0 left=%0d right=%0d", $signed(left_o), $signed(right_o));
    endtask

    task automatic test_full_load();
        int vc, vn, rc, bc;
        bit ok;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = attr(2'd0, 6'd63, 1'b1, 1'b1, 6'd63, 16'h0000);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if ($signed(left_o) !== 31248 || $signed(right_o) !== 31248) begin errors++;
            $display("FAIL full_load: got %0d/%0d want 31248/31248", $signed(left_o), $signed(right_o)); end
        $display("full load left=%0d right=%0d", $signed(left_o), $signed(right_o));
    endtask

    task automatic test_phase_wrap();
        int vc, vn, rc, bc;
        bit ok;
        int exp_l [3];
        exp_l[0] = -1; exp_l[1] = 31; exp_l[2] = -1;
        do_reset();
        clear_mem();
        mem[0] = attr(2'd1, 6'd0, 1'b0, 1'b1, 6'd1, 16'hFFFF);
        for (int n = 0; n < 3; n++) begin
            sweep(0, 0, 0, vc, vn, rc, ok, bc);
            checks++; if ($signed(left_o) !== exp_l[n] || right_o !== 16'd0) begin errors++;
                $display("FAIL wrap_sweep%0d: got %0d/%0d want %0d/0", n, $signed(left_o), $signed(right_o), exp_l[n]); end
            $display("wrap sweep%0d left=%0d", n, $signed(left_o));
        end
    endtask

    task automatic test_back_to_back();
        int vc, vn, rc, bc;
        bit ok;
        do_reset();
        clear_mem();
        mem[0] = attr(2'd1, 6'd0, 1'b0, 1'b1, 6'd63, 16'h0800);
        sweep(5, 32, 0, vc, vn, rc, ok, bc);
        checks++; if (vn != 1 || vc != 33) begin errors++;
            $display("FAIL proto_valid: got count=%0d cycle=%0d want 1/33", vn, vc); end
        checks++; if (rc != 16 || !ok) begin errors++;
            $display("FAIL proto_rd: got count=%0d order_ok=%0d want 16/1", rc, ok); end
        checks++; if (bc != 32) begin errors++;
            $display("FAIL proto_busy: got %0d busy cycles want 32", bc); end
        checks++; if ($signed(left_o) !== -1953) begin errors++;
            $display("FAIL proto_out: got %0d want -1953", $signed(left_o)); end
        $display("protocol sweep valid_cycle=%0d reads=%0d busy=%0d left=%0d", vc, rc, bc, $signed(left_o));
        sweep(0, 0, 10, vc, vn, rc, ok, bc);
        checks++; if (vn != 0) begin errors++;
            $display("FAIL abort_valid: got %0d valid pulses want 0", vn); end
        checks++; if (left_o !== 16'd0) begin errors++;
            $display("FAIL abort_out: got %0d want 0", $signed(left_o)); end
        $display("aborted sweep valid_count=%0d", vn);
        sweep(0, 0, 0, vc, vn, rc, ok, bc);
        checks++; if ($signed(left_o) !== -1953 || vc != 33) begin errors++;
            $display("FAIL fresh_after_reset: got %0d cycle=%0d want -1953/33", $signed(left_o), vc); end
        $display("fresh sweep left=%0d valid_cycle=%0d", $signed(left_o), vc);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_sawtooth();
        test_pulse();
        test_full_load();
        test_phase_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_psg_voice_seq.md
# audio_psg_voice_seq

Programmable sound generator voice sequencer. It sits directly downstream of the 16-entry PSG attribute RAM. On each sample tick it walks the 16 voices once and reads each 32-bit attribute word through the RAM's registered read port. Per voice it advances a private phase accumulator, generates the waveform, scales it by volume and sums it into left/right totals, then presents one signed stereo sample to the audio mixer.

## Interface
- No parameters. Voice count is fixed at 16, phase width at 17 bits, output width at 16 bits.
- `clk_i` in 1: system clock; also clocks the attribute RAM read port.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: sample tick, one-cycle pulse; honoured only in IDLE.
- `rd_en_o` out 1: attribute RAM read enable.
- `rd_addr_o` out 4: attribute RAM read address (voice index).
- `rd_data_i` in 32: attribute word; valid one cycle after its `rd_addr_o`/`rd_en_o` cycle.
  - [15:0] frequency
  - [21:16] volume
  - [22] left enable
  - [23] right enable
  - [29:24] pulse width
  - [31:30] waveform
- `busy_o` out 1: sweep in progress.
- `left_o` out 16: signed left sample; held between sweeps.
- `right_o` out 16: signed right sample; held between sweeps.
- `valid_o` out 1: one-cycle pulse when `left_o`/`right_o` update.

## Operation
- **State machine:** IDLE, ADDR, PROC. Voice counter `v` is 4 bits.
- **IDLE:** on `start_i`, clear `v` and both accumulators, then go to ADDR.
- **ADDR:** `rd_en_o`=1, `rd_addr_o`=`v`, then go to PROC.
- **PROC:** `rd_en_o`=0. Using `rd_data_i`:
  - `ph_new = ph[v] + freq`, mod 2^17. Write `ph_new` back to `ph[v]`.
  - `p = ph_new[16:11]`.
  - Unsigned wave value `u` (6 bits) by waveform:
    - 0 pulse: `u = (p < pw) ? 63 : 0`.
    - 1 sawtooth: `u = p`.
    - 2 triangle: `u = ph_new[16] ? ~ph_new[15:10] : ph_new[15:10]`.
    - 3 noise: `u = lfsr[5:0]`.
  - `s = u - 32`, signed 6 bits, range -32..31.
  - `prod = s * vol`, signed 12 bits. Volume 0 gives 0, but the phase still advances.
  - Add `prod` (sign-extended) to the left accumulator if left enable is set, and to the right accumulator if right enable is set. The 16-bit accumulators cannot overflow: max magnitude is 16 × 2016.
  - If `v` < 15: increment `v`, go to ADDR.
  - If `v` = 15: load `left_o`/`right_o` with the final sums including voice 15, set `valid_o`, go to IDLE.
- **Noise LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Steps once per PROC cycle regardless of waveform. Reset seed 16'h0001.
- **`busy_o`:** 1 in ADDR and PROC.
- **Reset values:**
  - state IDLE, `v`=0, all 16 phases 0, LFSR 16'h0001
  - accumulators 0, `left_o`/`right_o` 0
  - `valid_o`, `busy_o`, `rd_en_o` 0, `rd_addr_o` 0
- **Reset mid-sweep:** the sweep aborts, no `valid_o` is produced, and phases return to 0.
- **`start_i` while busy:** ignored, with no queuing. The sweep in progress is unaffected.
- **Phase wrap:** modulo 2^17, with no saturation.

## Timing
- `start_i` is sampled high in IDLE at cycle T.
- Voice n: ADDR at cycle T+1+2n, PROC at cycle T+2+2n.
- Voice 15 PROC is at T+32. `valid_o`=1 and the new `left_o`/`right_o` are visible in cycle T+33.
- `busy_o` is high for T+1..T+32. The FSM is back in IDLE in T+33, and a `start_i` in T+33 is accepted.
- Minimum sample period is 33 cycles. Outputs change only on the `valid_o` cycle.
- `rd_en_o` is high in exactly 16 cycles per sweep, with addresses 0..15 in order.

## Test plan
- **Reset:** assert `rst_n_i`=0 asynchronously mid-cycle → all outputs 0 immediately; `start_i` ignored while in reset.
- **Sawtooth:** voice 0 = {wave 1, vol 63, L=1, R=0, freq 16'h0800}, others 0.
  - Sweep 1 → `left_o`=-1953, `right_o`=0.
  - Sweep 2 → `left_o`=-1890.
  - `valid_o` exactly at T+33 each time.
- **Pulse:** voice 3 = {wave 0, pw 32, vol 63, L=R=1, freq 0} → `left_o`=`right_o`=1953.
  - With pw 0 instead → both -2016.
- **Full load:** all 16 voices = pulse, pw 63, vol 63, L=R=1, freq 0 → `left_o`=`right_o`=31248, no overflow.
- **Phase wrap:** voice 0 sawtooth, vol 1, L=1, freq 16'hFFFF.
  - Phases over three sweeps: 17'h0FFFF, 17'h1FFFE, 17'h0FFFD.
  - `left_o` over the same sweeps: -1, 31, -1.
- **Protocol:**
  - `start_i` pulsed at T+5 and T+32 → ignored; exactly one `valid_o`; `rd_addr_o` sequence 0..15.
  - `rst_n_i` low at T+10 → no `valid_o`, phases cleared.
  - A fresh start after reset → same result as the sawtooth test's first sweep.
